// File: rtl/draw_text_overlay_if.sv
// VGA timing + RGB bundle shared by consecutive video stages.
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport master (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport slave  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport out    (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport in     (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/draw_text_overlay.sv
// Text overlay: delays the VGA stream to meet font ROM data and composites glyph pixels.
// Optional TEXT_BLINK_EN: 6-bit frame counter blanks the glyphs for 32 of every 64 frames.
module draw_text_overlay #(
    parameter int unsigned X_START   = 280,
    parameter int unsigned Y_START   = 104,
    parameter int unsigned CHAR_W    = 8,
    parameter int unsigned CHAR_H    = 16,
    parameter int unsigned NUM_CHARS = 16,
    parameter int unsigned ROM_LAT   = 1,
    parameter logic [11:0] TEXT_RGB  = 12'hFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_pixels,
    vga_if.in          vga_in,
    vga_if.out         vga_out
);

    localparam int unsigned CNT_W = 11;
    localparam int unsigned X_END = X_START + NUM_CHARS * CHAR_W;
    localparam int unsigned Y_END = Y_START + CHAR_H;

    typedef struct packed {
        logic [CNT_W-1:0] vcount;
        logic [CNT_W-1:0] hcount;
        logic             vsync;
        logic             hsync;
        logic             vblnk;
        logic             hblnk;
        logic [11:0]      rgb;
    } vga_sample_t;

    vga_sample_t w_in;
    vga_sample_t w_al;
    vga_sample_t w_next;
    vga_sample_t r_pipe [ROM_LAT];
    vga_sample_t r_out;

    logic       w_in_box;
    logic [2:0] w_col;
    logic       w_pix;
    logic       w_blink_on;

    always_comb begin
        w_in.vcount = vga_in.vcount;
        w_in.hcount = vga_in.hcount;
        w_in.vsync  = vga_in.vsync;
        w_in.hsync  = vga_in.hsync;
        w_in.vblnk  = vga_in.vblnk;
        w_in.hblnk  = vga_in.hblnk;
        w_in.rgb    = vga_in.rgb;
    end

    // Delay line; the last stage is aligned with char_pixels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(ROM_LAT); i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_in;
            for (int i = 1; i < int'(ROM_LAT); i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_al = r_pipe[ROM_LAT-1];

    assign w_in_box = (w_al.hcount >= CNT_W'(X_START)) && (w_al.hcount < CNT_W'(X_END)) &&
                      (w_al.vcount >= CNT_W'(Y_START)) && (w_al.vcount < CNT_W'(Y_END));

    // Only the low 3 bits of (hc - X_START) matter, so subtract modulo 8
    assign w_col = 3'(w_al.hcount[2:0] - 3'(X_START));
    assign w_pix = char_pixels[3'd7 - w_col];

`ifdef TEXT_BLINK_EN
    logic [5:0] r_frame_cnt;
    logic       r_vs_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= '0;
            r_vs_prev   <= 1'b0;
        end else begin
            r_vs_prev <= w_al.vsync;
            if (w_al.vsync && !r_vs_prev) r_frame_cnt <= r_frame_cnt + 6'd1;
        end
    end

    assign w_blink_on = ~r_frame_cnt[5];
`else
    assign w_blink_on = 1'b1;
`endif

    always_comb begin
        w_next = w_al;
        if (w_al.hblnk || w_al.vblnk) begin
            w_next.rgb = 12'h000;
        end else if (w_in_box && w_pix && w_blink_on) begin
            w_next.rgb = TEXT_RGB;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_out <= '0;
        else      r_out <= w_next;
    end

    assign vga_out.vcount = r_out.vcount;
    assign vga_out.hcount = r_out.hcount;
    assign vga_out.vsync  = r_out.vsync;
    assign vga_out.hsync  = r_out.hsync;
    assign vga_out.vblnk  = r_out.vblnk;
    assign vga_out.hblnk  = r_out.hblnk;
    assign vga_out.rgb    = r_out.rgb;

endmodule

// File: tb/tb_draw_text_overlay.sv
// Self-checking bench for draw_text_overlay: vector table, random stream vs. reference model.
module tb_draw_text_overlay;

    localparam int LAT = 1;
    localparam int X0  = 280;
    localparam int Y0  = 104;
    localparam int NCH = 16;
    localparam int CH  = 16;
    localparam int NV  = 18;

    typedef struct packed {
        logic [10:0] vc;
        logic [10:0] hc;
        logic        vs;
        logic        hs;
        logic        vb;
        logic        hb;
        logic [11:0] rgb;
    } smp_t;

    typedef struct {
        int          hc;
        int          vc;
        bit          hb;
        bit          vb;
        logic [7:0]  pix;
        logic [11:0] exp_rgb;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] char_pixels = 8'h00;

    vga_if vin();
    vga_if vout();

    draw_text_overlay #(.ROM_LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .char_pixels (char_pixels),
        .vga_in      (vin),
        .vga_out     (vout)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    smp_t q_exp [$];
    logic [7:0] q_pix [$];
    bit   q_chk [$];
    int   frames_m = 0;
    bit   vs_prev_m = 1'b0;
    vec_t vt [NV];

    // Reference: box membership, glyph column and blink phase from plain integer arithmetic
    function automatic smp_t model(input smp_t s, input logic [7:0] pix);
        smp_t e;
        int   hc = int'(s.hc);
        int   vc = int'(s.vc);
        bit   inbox = (hc >= X0) && (hc < X0 + NCH * 8) && (vc >= Y0) && (vc < Y0 + CH);
        bit   on = 1'b1;
        bit   lit = 1'b0;
`ifdef TEXT_BLINK_EN
        on = ((frames_m / 32) % 2) == 0;
`endif
        if (inbox) lit = pix[7 - ((hc - X0) % 8)];
        e = s;
        if (s.hb || s.vb)  e.rgb = 12'h000;
        else if (lit && on) e.rgb = 12'hFFF;
        return e;
    endfunction

    function automatic smp_t read_out();
        return {vout.vcount, vout.hcount, vout.vsync, vout.hsync, vout.vblnk, vout.hblnk, vout.rgb};
    endfunction

    task automatic check(input smp_t got, input smp_t exp, input string tag);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic smp_t mk(input int hc, input int vc, input bit vs, input bit hs,
                                input bit vb, input bit hb, input logic [11:0] rgb);
        smp_t s;
        s.vc = 11'(vc); s.hc = 11'(hc); s.vs = vs; s.hs = hs;
        s.vb = vb; s.hb = hb; s.rgb = rgb;
        return s;
    endfunction

    // One pixel clock: drive sample + ROM data for the sample LAT cycles back, then compare
    task automatic tick(input smp_t s, input logic [7:0] pix, input bit chk,
                        input bit use_exp, input logic [11:0] exp_rgb, input string tag);
        smp_t e;
        int   n;
        e = model(s, pix);
        if (use_exp) e.rgb = exp_rgb;
`ifdef TEXT_BLINK_EN
        if (s.vs && !vs_prev_m) frames_m = (frames_m + 1) % 64;
        vs_prev_m = s.vs;
`endif
        q_exp.push_back(e);
        q_pix.push_back(pix);
        q_chk.push_back(chk);
        vin.vcount = s.vc; vin.hcount = s.hc; vin.vsync = s.vs; vin.hsync = s.hs;
        vin.vblnk = s.vb; vin.hblnk = s.hb; vin.rgb = s.rgb;
        n = q_pix.size();
        char_pixels = (n > LAT) ? q_pix[n-1-LAT] : 8'h00;
        @(posedge clk); #1;
        if (n > LAT) begin
            if (q_chk[n-1-LAT]) check(read_out(), q_exp[n-1-LAT], tag);
        end else begin
            check(read_out(), '0, "refill");
        end
    endtask

    function automatic smp_t rnd_smp();
        return mk($urandom_range(270, 420), $urandom_range(98, 126), ($urandom % 40) == 0,
                  1'($urandom), ($urandom % 20) == 0, ($urandom % 10) == 0, 12'($urandom));
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp_t s = rnd_smp();
            vin.vcount = s.vc; vin.hcount = s.hc; vin.vsync = s.vs; vin.hsync = s.hs;
            vin.vblnk = s.vb; vin.hblnk = s.hb; vin.rgb = s.rgb;
            char_pixels = 8'($urandom);
            @(posedge clk); #1;
            check(read_out(), '0, "reset");
        end
        rst = 1'b1;
        q_exp.delete(); q_pix.delete(); q_chk.delete();
        frames_m = 0; vs_prev_m = 1'b0;
    endtask

    initial begin
        vt[0]  = '{280, 104, 0, 0, 8'h81, 12'hFFF};
        vt[1]  = '{287, 104, 0, 0, 8'h81, 12'hFFF};
        vt[2]  = '{288, 104, 0, 0, 8'h81, 12'hFFF};
        vt[3]  = '{295, 104, 0, 0, 8'h81, 12'hFFF};
        vt[4]  = '{281, 104, 0, 0, 8'h81, 12'h123};
        vt[5]  = '{284, 104, 0, 0, 8'h81, 12'h123};
        vt[6]  = '{286, 104, 0, 0, 8'h81, 12'h123};
        vt[7]  = '{279, 104, 0, 0, 8'hFF, 12'h123};
        vt[8]  = '{408, 104, 0, 0, 8'hFF, 12'h123};
        vt[9]  = '{407, 104, 0, 0, 8'h81, 12'hFFF};
        vt[10] = '{280, 103, 0, 0, 8'hFF, 12'h123};
        vt[11] = '{280, 120, 0, 0, 8'hFF, 12'h123};
        vt[12] = '{280, 119, 0, 0, 8'h81, 12'hFFF};
        vt[13] = '{300, 110, 1, 0, 8'hFF, 12'h000};
        vt[14] = '{300, 110, 0, 1, 8'hFF, 12'h000};
        vt[15] = '{0,   0,   0, 0, 8'hFF, 12'h123};
        vt[16] = '{283, 110, 0, 0, 8'h10, 12'hFFF};
        vt[17] = '{284, 110, 0, 0, 8'h10, 12'h123};

        do_reset();

        // Latency: first sample emerges exactly LAT+1 cycles after release, syncs intact
        tick(mk(300, 110, 1'b1, 1'b1, 1'b0, 1'b0, 12'h123), 8'h00, 1'b1, 1'b1, 12'h123, "latency");

        for (int i = 0; i < NV; i++) begin
            tick(mk(vt[i].hc, vt[i].vc, 1'b0, 1'(i), vt[i].vb, vt[i].hb, 12'h123),
                 vt[i].pix, 1'b1, 1'b1, vt[i].exp_rgb, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 1500; i++) begin
            smp_t s = rnd_smp();
            if ((i % 16) == 0) s = mk($urandom_range(0, 2047), $urandom_range(0, 2047),
                                      1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom));
            tick(s, 8'($urandom), 1'b1, 1'b0, 12'h000, "random");
        end
        for (int i = 0; i < LAT; i++) tick('0, 8'h00, 1'b0, 1'b0, 12'h000, "flush");

        // Reset in the middle of traffic must clear the pipe again
        do_reset();
        tick(mk(280, 104, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456), 8'hFF, 1'b1, 1'b1, 12'hFFF, "post_reset");
        for (int i = 0; i < LAT; i++) tick('0, 8'h00, 1'b0, 1'b0, 12'h000, "flush");

`ifdef TEXT_BLINK_EN
        do_reset();
        for (int f = 0; f <= 64; f++) begin
            if (f > 0) begin
                tick(mk(0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000), 8'h00, 1'b0, 1'b0, 12'h000, "vs");
                tick(mk(1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000), 8'h00, 1'b0, 1'b0, 12'h000, "vs");
            end
            tick(mk(280, 104, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A5), 8'hFF, 1'b1, 1'b1,
                 (f < 32 || f == 64) ? 12'hFFF : 12'h0A5, $sformatf("blink_f%0d", f));
        end
        for (int i = 0; i < LAT; i++) tick('0, 8'h00, 1'b0, 1'b0, 12'h000, "flush");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
